// File: rtl/glyph_scan_ctrl.sv
// glyph_scan_ctrl
// Sequencer for the 1-bit digit glyph ROMs. It walks every address of one
// digit ROM and streams each pixel, tagged with its row and column, to the
// display writer over a valid/ready interface. A 2-entry output FIFO absorbs
// the ROM's 1-cycle read latency and any downstream backpressure.
//
// Ports
//   clock      rising-edge clock, shared with the ROMs
//   rst_n      asynchronous active-low reset
//   start      scan request for `digit`, sampled only while idle
//   digit      glyph code to render (0..DIGIT_MAX)
//   abort      cancel the scan in progress (overrides start while idle)
//   rom_sel    ROM mux select, latched from `digit` on an accepted start
//   rom_addr   address to the selected ROM (row*GLYPH_W + col)
//   rom_q      muxed ROM data, valid the cycle after rom_addr is sampled
//   pix_valid  pixel available at the FIFO head
//   pix_ready  consumer accepts the pixel
//   pix_data   pixel value
//   pix_col    pixel column
//   pix_row    pixel row
//   pix_last   final pixel of the glyph
//   busy       scan or drain in progress
//   done       one-cycle pulse when the last pixel has left the block
//   err        one-cycle pulse when a start carries an out-of-range digit
module glyph_scan_ctrl #(
  parameter int  GLYPH_W   = 8,
  parameter int  GLYPH_H   = 16,
  parameter int  ADDR_W    = 7,
  parameter int  DIGIT_MAX = 9,
  localparam int COL_W     = $clog2(GLYPH_W),
  localparam int ROW_W     = $clog2(GLYPH_H)
) (
  input  logic              clock,
  input  logic              rst_n,
  input  logic              start,
  input  logic [3:0]        digit,
  input  logic              abort,
  output logic [3:0]        rom_sel,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic              rom_q,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic              pix_data,
  output logic [COL_W-1:0]  pix_col,
  output logic [ROW_W-1:0]  pix_row,
  output logic              pix_last,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam logic [3:0]        DIGIT_LIM = 4'(DIGIT_MAX);
  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN} state_t;

  function automatic logic is_last(input logic [ADDR_W-1:0] a);
    return a == LAST_ADDR;
  endfunction

  state_t            state, state_nx;
  logic              accept, issue, pop, push;
  logic [1:0]        fifo_cnt;
  logic [1:0]        wr_slot;
  logic [2:0]        occ;

  logic              vld_p1;
  logic [ADDR_W-1:0] addr_p1;
  logic [1:0]        dat_p2;
  logic [ADDR_W-1:0] addr_p2 [2];

  assign pix_valid = (fifo_cnt != 2'd0);
  assign pop       = pix_valid & pix_ready;
  // An abort flushes the FIFO, so the ROM result of an in-flight read is dropped.
  assign push      = vld_p1 & ~abort;
  assign occ       = {1'b0, fifo_cnt} + {2'b00, vld_p1};
  assign wr_slot   = fifo_cnt - {1'b0, pop};

  // State register
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = SCAN;
      SCAN: begin
        if (abort)                           state_nx = IDLE;
        else if (issue && is_last(rom_addr)) state_nx = DRAIN;
      end
      DRAIN:   if (abort || done) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Output / control decode
  always_comb begin
    accept = 1'b0;
    issue  = 1'b0;
    busy   = 1'b0;
    done   = 1'b0;
    err    = 1'b0;
    case (state)
      IDLE: begin
        accept = start && !abort && (digit <= DIGIT_LIM);
        err    = start && !abort && (digit > DIGIT_LIM);
      end
      SCAN: begin
        busy  = 1'b1;
        // Only issue when the result is guaranteed a FIFO slot after this
        // cycle's pop, counting the read already in flight.
        issue = !abort && (occ < (3'd2 + {2'b00, pop}));
      end
      DRAIN: begin
        busy = 1'b1;
        done = !abort && (fifo_cnt == 2'd0) && !vld_p1;
      end
      default: ;
    endcase
  end

  // Stage p0 -> p1: address issue, ROM read in flight
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      rom_sel  <= '0;
      rom_addr <= '0;
      vld_p1   <= 1'b0;
      fifo_cnt <= '0;
    end else begin
      vld_p1 <= issue;
      if (accept) begin
        rom_sel  <= digit;
        rom_addr <= '0;
      end else if (issue && !is_last(rom_addr)) begin
        rom_addr <= rom_addr + ADDR_W'(1);
      end
      if (abort) fifo_cnt <= '0;
      else       fifo_cnt <= fifo_cnt + 2'(push) - 2'(pop);
    end
  end

  always_ff @(posedge clock) begin
    if (issue) addr_p1 <= rom_addr;
  end

  // Stage p1 -> p2: ROM data captured into the 2-entry FIFO (entry 0 is the head)
  always_ff @(posedge clock) begin
    if (pop) begin
      dat_p2[0]  <= dat_p2[1];
      addr_p2[0] <= addr_p2[1];
    end
    if (push) begin
      if (wr_slot == 2'd0) begin
        dat_p2[0]  <= rom_q;
        addr_p2[0] <= addr_p1;
      end else begin
        dat_p2[1]  <= rom_q;
        addr_p2[1] <= addr_p1;
      end
    end
  end

  // FIFO storage is not reset; outputs are gated so they read 0 when empty.
  assign pix_data = pix_valid & dat_p2[0];
  assign pix_col  = pix_valid ? addr_p2[0][COL_W-1:0]      : '0;
  assign pix_row  = pix_valid ? addr_p2[0][ADDR_W-1:COL_W] : '0;
  assign pix_last = pix_valid & is_last(addr_p2[0]);

endmodule

// File: tb/tb_glyph_scan_ctrl.sv
// Self-checking bench for glyph_scan_ctrl: a behavioural ROM set drives rom_q,
// and the expected pixel stream for a digit is simply every ROM bit in
// address order tagged with row = a/8, col = a%8, last = (a == 127).
module tb_glyph_scan_ctrl;

  logic       clock = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [3:0] digit = 4'd0;
  logic       abort = 1'b0;
  logic       rom_q = 1'b0;
  logic       pix_ready = 1'b0;
  logic [3:0] rom_sel;
  logic [6:0] rom_addr;
  logic       pix_valid, pix_data, pix_last, busy, done, err;
  logic [2:0] pix_col;
  logic [3:0] pix_row;

  always #5 clock = ~clock;

  glyph_scan_ctrl dut (
    .clock     (clock),
    .rst_n     (rst_n),
    .start     (start),
    .digit     (digit),
    .abort     (abort),
    .rom_sel   (rom_sel),
    .rom_addr  (rom_addr),
    .rom_q     (rom_q),
    .pix_valid (pix_valid),
    .pix_ready (pix_ready),
    .pix_data  (pix_data),
    .pix_col   (pix_col),
    .pix_row   (pix_row),
    .pix_last  (pix_last),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  // Behavioural digit ROMs with registered read
  logic rom [10][128];
  always @(posedge clock)
    rom_q <= (rom_sel <= 4'd9) ? rom[int'(rom_sel)][int'(rom_addr)] : 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [8:0] exp_pix(input int d, input int a);
    logic [3:0] r;
    logic [2:0] c;
    r = 4'(a / 8);
    c = 3'(a % 8);
    return {rom[d][a], r, c, (a == 127)};
  endfunction

  logic [8:0]  cur;
  logic [23:0] outs;
  assign cur  = {pix_data, pix_row, pix_col, pix_last};
  assign outs = {rom_sel, rom_addr, pix_valid, pix_data, pix_col, pix_row, pix_last, busy, done, err};

  logic [8:0] got_q[$];
  int   cyc = 0, e0 = 0, first_vld = -1, done_cnt = 0, done_lat = -1, err_cnt = 0;
  int   rmode = 0;
  logic prev_stall = 1'b0;
  logic [8:0] prev_pix = '0;

  always @(posedge clock) cyc <= cyc + 1;

  // Monitor: sampled on the falling edge, away from the active edge
  always @(negedge clock) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) chk("stall_hold", 32'({pix_valid, cur}), 32'({1'b1, prev_pix}));
      if (busy) chk("fifo_le2", 32'(dut.fifo_cnt <= 2'd2), 32'd1);
      if (pix_valid && first_vld < 0) first_vld = cyc - e0;
      if (pix_valid && pix_ready) got_q.push_back(cur);
      if (done) begin
        done_cnt++;
        done_lat = cyc - e0;
      end
      if (err) err_cnt++;
      prev_stall = pix_valid && !pix_ready && !abort;
      prev_pix   = cur;
    end
  end

  // Consumer ready: 0 = always ready, 1 = pattern 1,0,0,1, 2 = random
  initial begin
    int k = 0;
    forever begin
      @(posedge clock);
      #1;
      k++;
      case (rmode)
        0:       pix_ready = 1'b1;
        1:       pix_ready = ((k % 4) == 0) || ((k % 4) == 3);
        default: pix_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  task automatic start_scan(input int d);
    got_q.delete();
    first_vld = -1;
    @(posedge clock); #1;
    start = 1'b1;
    digit = 4'(d);
    @(posedge clock); #1;
    start = 1'b0;
    e0 = cyc;
  endtask

  task automatic wait_done(input string tag, input int max_cyc, input int db);
    int t = 0;
    while (done_cnt == db && t < max_cyc) begin
      @(posedge clock);
      t++;
    end
    chk({tag, "_done_seen"}, 32'(done_cnt - db), 32'd1);
    repeat (4) @(posedge clock);
    #1;
    chk({tag, "_one_done"}, 32'(done_cnt - db), 32'd1);
    chk({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  task automatic check_stream(input string tag, input int d);
    chk({tag, "_npix"}, 32'(got_q.size()), 32'd128);
    for (int i = 0; i < 128 && i < got_q.size(); i++)
      chk($sformatf("%s_pix%0d", tag, i), 32'(got_q[i]), 32'(exp_pix(d, i)));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int db, ec, t, d;
    logic [7:0] v3, v7;
    logic zor;
    int nlast;
    logic [7:0] r3, r7;

    // ROM contents: digit 9 has the fixed rows; everything else random
    r3 = 8'b0111_1000;
    r7 = 8'b0111_1110;
    for (int dd = 0; dd < 10; dd++)
      for (int a = 0; a < 128; a++)
        rom[dd][a] = 1'($urandom_range(0, 1));
    for (int a = 0; a < 128; a++) begin
      if (a <= 24 || a >= 93) rom[9][a] = 1'b0;
      if (a >= 24 && a <= 31) rom[9][a] = r3[31 - a];
      if (a >= 56 && a <= 63) rom[9][a] = r7[63 - a];
    end

    // Reset state
    repeat (3) @(posedge clock);
    #1;
    chk("reset_outs", 32'(outs), 32'd0);
    @(negedge clock);
    rst_n = 1'b1;
    repeat (2) @(posedge clock);

    // Digit 9, always ready
    rmode = 0;
    db = done_cnt;
    start_scan(9);
    wait_done("t1", 300, db);
    chk("t1_done_lat", 32'(done_lat), 32'd130);
    chk("t1_first_vld", 32'(first_vld), 32'd2);
    chk("t1_rom_sel", 32'(rom_sel), 32'd9);
    check_stream("t1", 9);
    if (got_q.size() == 128) begin
      zor = 1'b0;
      nlast = 0;
      for (int i = 0; i < 8; i++) begin
        v3[7 - i] = got_q[24 + i][8];
        v7[7 - i] = got_q[56 + i][8];
      end
      for (int i = 0; i < 128; i++) begin
        if (i <= 24 || i >= 93) zor = zor | got_q[i][8];
        if (got_q[i][0]) nlast++;
      end
      chk("t1_row3", 32'(v3), 32'h78);
      chk("t1_row7", 32'(v7), 32'h7e);
      chk("t1_zero_regions", 32'(zor), 32'd0);
      chk("t1_nlast", 32'(nlast), 32'd1);
      chk("t1_last_tag", 32'(got_q[127][7:1]), 32'h7f);
    end

    // Digit 9, ready toggling 1,0,0,1
    rmode = 1;
    db = done_cnt;
    start_scan(9);
    wait_done("t2", 800, db);
    check_stream("t2", 9);

    // Out-of-range digit
    ec = err_cnt;
    start_scan(10);
    repeat (3) @(posedge clock);
    #1;
    chk("t3_err_pulse", 32'(err_cnt - ec), 32'd1);
    chk("t3_busy", 32'(busy), 32'd0);
    chk("t3_rom_sel", 32'(rom_sel), 32'd9);

    // Abort in idle overrides start
    @(posedge clock); #1;
    start = 1'b1; digit = 4'd3; abort = 1'b1;
    @(posedge clock); #1;
    digit = 4'd12;
    @(posedge clock); #1;
    start = 1'b0; abort = 1'b0;
    chk("t3_abort_idle_busy", 32'(busy), 32'd0);
    chk("t3_abort_idle_err", 32'(err_cnt - ec), 32'd1);

    rmode = 2;
    db = done_cnt;
    start_scan(3);
    wait_done("t3b", 800, db);
    check_stream("t3b", 3);
    chk("t3b_rom_sel", 32'(rom_sel), 32'd3);

    // Abort after the 40th handshake
    rmode = 0;
    db = done_cnt;
    start_scan(9);
    t = 0;
    while (got_q.size() < 40 && t < 300) begin
      @(posedge clock);
      t++;
    end
    chk("t4_reach40", 32'(got_q.size()), 32'd40);
    #1;
    abort = 1'b1;
    @(posedge clock); #1;
    abort = 1'b0;
    chk("t4_valid_off", 32'(pix_valid), 32'd0);
    chk("t4_busy_off", 32'(busy), 32'd0);
    for (int i = 0; i < 40 && i < got_q.size(); i++)
      chk($sformatf("t4_pre%0d", i), 32'(got_q[i]), 32'(exp_pix(9, i)));
    repeat (10) @(posedge clock);
    #1;
    chk("t4_no_done", 32'(done_cnt - db), 32'd0);
    chk("t4_still_off", 32'(pix_valid), 32'd0);
    start_scan(9);
    wait_done("t4r", 300, db);
    check_stream("t4r", 9);

    // Start while busy is ignored
    rmode = 2;
    db = done_cnt;
    ec = err_cnt;
    start_scan(9);
    repeat (20) @(posedge clock);
    #1;
    start = 1'b1; digit = 4'd1;
    @(posedge clock); #1;
    digit = 4'd13;
    @(posedge clock); #1;
    start = 1'b0;
    wait_done("t5", 800, db);
    check_stream("t5", 9);
    chk("t5_rom_sel", 32'(rom_sel), 32'd9);
    chk("t5_no_err", 32'(err_cnt - ec), 32'd0);

    // Asynchronous reset mid-scan
    rmode = 0;
    db = done_cnt;
    start_scan(9);
    repeat (30) @(posedge clock);
    #3;
    rst_n = 1'b0;
    #1;
    chk("t6_reset_outs", 32'(outs), 32'd0);
    repeat (2) @(posedge clock);
    #7;
    rst_n = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    chk("t6_idle", 32'(busy), 32'd0);
    chk("t6_no_valid", 32'(pix_valid), 32'd0);
    chk("t6_no_done", 32'(done_cnt - db), 32'd0);
    start_scan(9);
    wait_done("t6r", 300, db);
    check_stream("t6r", 9);

    // Randomized scans and rejected starts
    for (int it = 0; it < 6; it++) begin
      d = $urandom_range(0, 13);
      rmode = 2;
      if (d > 9) begin
        ec = err_cnt;
        start_scan(d);
        repeat (2) @(posedge clock);
        #1;
        chk($sformatf("r%0d_err", it), 32'(err_cnt - ec), 32'd1);
        chk($sformatf("r%0d_busy", it), 32'(busy), 32'd0);
      end else begin
        db = done_cnt;
        start_scan(d);
        wait_done($sformatf("r%0d", it), 800, db);
        check_stream($sformatf("r%0d", it), d);
        chk($sformatf("r%0d_rom_sel", it), 32'(rom_sel), 32'(d));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
